ct_ciu_req_buf: RTL and testbench
=================================

// Module: ct_ciu_req_buf
// PURPOSE
//  NUM-entry request holding buffer sitting directly upstream of the CIU age-matrix
//  priority picker (ct_prio). Captures incoming requests into free entries and drives
//  the picker's valid vector. Takes back its one-hot sel, presents the selected payload
//  on a valid/ready output port, and pulses the picker's clr on acceptance to free the entry.
// PARAMETERS
//  NUM    4   number of request entries; equals ct_prio NUM
//  DW     64  request payload width
//  CNT_W  3   width of entry_cnt; must satisfy 2^CNT_W > NUM
// PORTS
//  clk        in   1      clock
//  rst_b      in   1      reset, asynchronous, active-low
//  in_vld     in   1      upstream request valid
//  in_data    in   DW     upstream request payload
//  in_rdy     out  1      a free entry exists (registered state only)
//  arb_valid  out  NUM    to ct_prio valid
//  arb_sel    in   NUM    from ct_prio sel; one-hot or zero
//  arb_clr    out  1      to ct_prio clr; equals out_vld & out_rdy & ~bypass
//  out_vld    out  1      request presented downstream
//  out_data   out  DW     payload of presented request
//  out_rdy    in   1      downstream accepts
//  entry_cnt  out  CNT_W  number of occupied entries
//  empty      out  1      entry_cnt == 0
//  full       out  1      entry_cnt == NUM
// BEHAVIOUR
//  - Reset: all entries FREE, lock cleared, entry_cnt=0, empty=1, full=0, in_rdy=1,
//    out_vld=0, arb_valid=0, arb_clr=0. Payload registers are not reset.
//  - Per-entry FSM: FREE -> PEND on allocation. PEND -> LOCK when the entry is
//    presented and out_rdy=0. PEND/LOCK -> FREE on acceptance.
//  - Allocation: on in_vld & in_rdy, the lowest-index FREE entry captures in_data and
//    goes PEND next cycle. The entry is visible on arb_valid one cycle after capture.
//  - arb_valid[i] = entry i in PEND or LOCK. While any entry is LOCK, arb_valid is
//    masked to that entry only. A newly arrived, higher-priority entry cannot steal a
//    presentation already shown downstream, so out_data stays stable until accepted.
//  - out_vld = |arb_sel. out_data = AND-OR mux of entry payloads by arb_sel.
//  - Acceptance: out_vld & out_rdy. The selected entry goes FREE next cycle, any lock
//    clears, and arb_clr=1 for that cycle only.
//  - At most one entry is in LOCK. Lock is set only when out_vld & ~out_rdy.
//  - Simultaneous alloc + free: the freed entry is not reusable in the same cycle
//    (in_rdy derives from registered state). entry_cnt is unchanged net.
//  - Full: in_rdy=0; in_vld is ignored. Empty: out_vld=0 (except bypass).
//  - A non-one-hot arb_sel is illegal; assertion only, no recovery.
//  - An asynchronous reset mid-transfer drops all entries and the lock. Upstream must
//    re-send.
// CONFIGURATION
//  CT_REQ_BUF_BYPASS_EN
//  - Defined: when empty & in_vld & out_rdy, the request passes combinationally.
//    out_vld=1, out_data=in_data, no entry is allocated, arb_clr=0, entry_cnt unchanged.
//    If out_rdy=0, the request allocates normally.
//  - Undefined: no bypass. Minimum in-to-out latency is 1 cycle.
// TESTING
//  1. Reset, then one request (data 0xA5) with out_rdy=1 -> out_vld and out_data=0xA5
//     one cycle after capture; arb_clr pulses once; empty=1 afterwards.
//  2. Fill 4 entries with out_rdy=0 -> full=1, in_rdy=0, entry_cnt=4; a 5th in_vld is
//     not accepted and no entry is overwritten.
//  3. Entry 2 presented with out_rdy=0, then a request lands in entry 0 (higher age
//     priority) -> out_data stays on entry 2 until accepted, then entry 0 is presented.
//  4. Full buffer with accept and new in_vld in the same cycle -> in_rdy=0 that cycle,
//     entry_cnt 4->3, new request accepted the next cycle into the freed entry.
//  5. Assert rst_b=0 while LOCK and 3 entries are held -> next cycle out_vld=0,
//     entry_cnt=0, in_rdy=1.
//  6. With CT_REQ_BUF_BYPASS_EN, empty buffer, in_vld and out_rdy both 1, data 0x3C ->
//     out_data=0x3C the same cycle, arb_clr=0, entry_cnt stays 0. Without the macro ->
//     output appears the next cycle.

Source files
------------

// File: rtl/ct_ciu_req_buf_if.sv
// Request-buffer bus: upstream request port, ct_prio valid/sel/clr link and downstream output port.
// slave = buffer side, master = environment (upstream, picker and downstream consumer).
interface ct_ciu_req_buf_if #(
    parameter int NUM   = 4,
    parameter int DW    = 64,
    parameter int CNT_W = 3
);
    logic             in_vld;
    logic [DW-1:0]    in_data;
    logic             in_rdy;
    logic [NUM-1:0]   arb_valid;
    logic [NUM-1:0]   arb_sel;
    logic             arb_clr;
    logic             out_vld;
    logic [DW-1:0]    out_data;
    logic             out_rdy;
    logic [CNT_W-1:0] entry_cnt;
    logic             empty;
    logic             full;

    modport slave (
        input  in_vld, in_data, arb_sel, out_rdy,
        output in_rdy, arb_valid, arb_clr, out_vld, out_data, entry_cnt, empty, full
    );

    modport master (
        output in_vld, in_data, arb_sel, out_rdy,
        input  in_rdy, arb_valid, arb_clr, out_vld, out_data, entry_cnt, empty, full
    );
endinterface

// File: rtl/ct_ciu_req_buf.sv
// NUM-entry request holding buffer feeding the ct_prio age-matrix picker.
// Optional combinational empty-buffer bypass: define CT_REQ_BUF_BYPASS_EN.
module ct_ciu_req_buf_entry #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          alloc,
    input  logic          sel,
    input  logic          acc,
    input  logic          out_rdy,
    input  logic [DW-1:0] in_data,
    output logic          busy,
    output logic          locked,
    output logic [DW-1:0] data
);
    typedef enum logic [1:0] {FREE, PEND, LOCK} st_e;
    st_e st_q, st_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) st_q <= FREE;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            FREE: if (alloc) st_d = PEND;
            // A presentation that stalls is pinned until the consumer takes it
            PEND: if (sel & acc) st_d = FREE;
                  else if (sel & ~out_rdy) st_d = LOCK;
            LOCK: if (sel & acc) st_d = FREE;
            default: st_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (alloc) data <= in_data;
    end

    assign busy   = (st_q != FREE);
    assign locked = (st_q == LOCK);
endmodule

module ct_ciu_req_buf #(
    parameter int NUM   = 4,
    parameter int DW    = 64,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_b,
    ct_ciu_req_buf_if.slave bus
);
    logic [NUM-1:0]         busy_vec;
    logic [NUM-1:0]         lock_vec;
    logic [NUM-1:0]         free_vec;
    logic [NUM-1:0]         alloc_vec;
    logic [NUM-1:0][DW-1:0] ent_data;
    logic [DW-1:0]          sel_data;
    logic [CNT_W-1:0]       cnt_q;
    logic                   bypass;
    logic                   alloc_en;
    logic                   acc;

`ifdef CT_REQ_BUF_BYPASS_EN
    assign bypass = bus.empty & bus.in_vld & bus.out_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign bus.full   = (cnt_q == CNT_W'(NUM));
    assign bus.empty  = (cnt_q == '0);
    assign bus.in_rdy = ~bus.full;
    assign bus.entry_cnt = cnt_q;

    assign alloc_en  = bus.in_vld & bus.in_rdy & ~bypass;
    assign free_vec  = ~busy_vec;
    // Isolate the lowest free entry
    assign alloc_vec = alloc_en ? (free_vec & (~free_vec + NUM'(1))) : '0;

    assign bus.arb_valid = (|lock_vec) ? lock_vec : busy_vec;

    for (genvar i = 0; i < NUM; i++) begin : g_ent
        ct_ciu_req_buf_entry #(.DW(DW)) u_ent (
            .clk     (clk),
            .rst_b   (rst_b),
            .alloc   (alloc_vec[i]),
            .sel     (bus.arb_sel[i]),
            .acc     (acc),
            .out_rdy (bus.out_rdy),
            .in_data (bus.in_data),
            .busy    (busy_vec[i]),
            .locked  (lock_vec[i]),
            .data    (ent_data[i])
        );
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM; i++) sel_data |= ent_data[i] & {DW{bus.arb_sel[i]}};
    end

    assign bus.out_vld  = (|bus.arb_sel) | bypass;
    assign bus.out_data = bypass ? bus.in_data : sel_data;
    assign acc          = bus.out_vld & bus.out_rdy & ~bypass;
    assign bus.arb_clr  = acc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cnt_q <= '0;
        else        cnt_q <= cnt_q + CNT_W'(alloc_en) - CNT_W'(acc);
    end

    a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(bus.arb_sel));
    a_one_lock:   assert property (@(posedge clk) disable iff (!rst_b) $onehot0(lock_vec));
endmodule

// File: tb/tb_ct_ciu_req_buf.sv
// Bench for ct_ciu_req_buf: directed scenarios plus randomized traffic against a queue-level model.
// A lowest-index-first picker stands in for ct_prio.
module tb_ct_ciu_req_buf;
    localparam int NUM = 4, DW = 64, CNT_W = 3, IW = $clog2(NUM);

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_chk = 0, n_pass = 0;

    ct_ciu_req_buf_if #(.NUM(NUM), .DW(DW), .CNT_W(CNT_W)) bus ();
    ct_ciu_req_buf #(.NUM(NUM), .DW(DW), .CNT_W(CNT_W)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        bus.arb_sel = '0;
        for (int i = NUM - 1; i >= 0; i--) if (bus.arb_valid[i]) bus.arb_sel = NUM'(1) << i;
    end

    // Reference model: which slots hold a request, their payloads, and the pinned slot if any
    logic [NUM-1:0] m_busy;
    logic [DW-1:0]  m_data [NUM];
    logic           m_lock_v;
    logic [IW-1:0]  m_lock_i, m_pick, m_free;
    logic           m_pick_v, m_byp, m_ovld, m_clr;
    logic [NUM-1:0] m_valid;
    logic [DW-1:0]  m_odata;
    int             m_cnt;

    always_comb begin
        m_cnt   = $countones(m_busy);
        m_valid = m_lock_v ? (NUM'(1) << m_lock_i) : m_busy;
        m_pick  = '0; m_pick_v = 1'b0; m_free = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (m_valid[i]) begin m_pick = IW'(i); m_pick_v = 1'b1; end
            if (!m_busy[i]) m_free = IW'(i);
        end
`ifdef CT_REQ_BUF_BYPASS_EN
        m_byp = (m_cnt == 0) && bus.in_vld && bus.out_rdy;
`else
        m_byp = 1'b0;
`endif
        m_ovld  = m_pick_v | m_byp;
        m_odata = m_byp ? bus.in_data : m_data[m_pick];
        m_clr   = m_pick_v & bus.out_rdy;
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_busy <= '0; m_lock_v <= 1'b0; m_lock_i <= '0;
        end else begin
            if (m_pick_v && bus.out_rdy) begin
                m_busy[m_pick] <= 1'b0; m_lock_v <= 1'b0;
            end else if (m_pick_v) begin
                m_lock_v <= 1'b1; m_lock_i <= m_pick;
            end
            if (bus.in_vld && m_cnt < NUM && !m_byp) begin
                m_busy[m_free] <= 1'b1; m_data[m_free] <= bus.in_data;
            end
        end
    end

    // Apply inputs just after a rising edge, then stop at the falling edge for checking
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        @(posedge clk); #1;
        bus.in_vld = v; bus.in_data = d; bus.out_rdy = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.in_rdy !== 1'b1) $display("FAIL rst_in_rdy got=%b exp=1", bus.in_rdy); else n_pass++;
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", bus.empty); else n_pass++;
        n_chk++; if (bus.full !== 1'b0) $display("FAIL rst_full got=%b exp=0", bus.full); else n_pass++;
        n_chk++; if (bus.entry_cnt !== 3'd0) $display("FAIL rst_cnt got=%0d exp=0", bus.entry_cnt); else n_pass++;
        n_chk++; if (bus.out_vld !== 1'b0) $display("FAIL rst_out_vld got=%b exp=0", bus.out_vld); else n_pass++;
        n_chk++; if (bus.arb_valid !== 4'b0) $display("FAIL rst_arb_valid got=%b exp=0000", bus.arb_valid); else n_pass++;
        n_chk++; if (bus.arb_clr !== 1'b0) $display("FAIL rst_arb_clr got=%b exp=0", bus.arb_clr); else n_pass++;
        @(posedge clk); #1 rst_b = 1'b1;
    endtask

    // One request through an empty buffer with the consumer ready
    task automatic test_single(input logic [DW-1:0] d);
        step(1'b1, d, 1'b1);
`ifdef CT_REQ_BUF_BYPASS_EN
        n_chk++; if (bus.out_vld !== 1'b1) $display("FAIL byp_vld got=%b exp=1", bus.out_vld); else n_pass++;
        n_chk++; if (bus.out_data !== d) $display("FAIL byp_data got=%h exp=%h", bus.out_data, d); else n_pass++;
        n_chk++; if (bus.arb_clr !== 1'b0) $display("FAIL byp_clr got=%b exp=0", bus.arb_clr); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.entry_cnt !== 3'd0) $display("FAIL byp_cnt got=%0d exp=0", bus.entry_cnt); else n_pass++;
`else
        n_chk++; if (bus.out_vld !== 1'b0) $display("FAIL single_vld0 got=%b exp=0", bus.out_vld); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_vld !== 1'b1) $display("FAIL single_vld1 got=%b exp=1", bus.out_vld); else n_pass++;
        n_chk++; if (bus.out_data !== d) $display("FAIL single_data got=%h exp=%h", bus.out_data, d); else n_pass++;
        n_chk++; if (bus.arb_clr !== 1'b1) $display("FAIL single_clr got=%b exp=1", bus.arb_clr); else n_pass++;
        n_chk++; if (bus.entry_cnt !== 3'd1) $display("FAIL single_cnt got=%0d exp=1", bus.entry_cnt); else n_pass++;
        step(1'b0, '0, 1'b1);
`endif
        n_chk++; if (bus.arb_clr !== 1'b0) $display("FAIL single_clr_end got=%b exp=0", bus.arb_clr); else n_pass++;
        n_chk++; if (bus.out_vld !== 1'b0) $display("FAIL single_vld_end got=%b exp=0", bus.out_vld); else n_pass++;
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL single_empty got=%b exp=1", bus.empty); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < NUM; i++) step(1'b1, DW'(64'h10 + i), 1'b0);
        step(1'b1, 64'hFF, 1'b0);
        n_chk++; if (bus.full !== 1'b1) $display("FAIL full_full got=%b exp=1", bus.full); else n_pass++;
        n_chk++; if (bus.in_rdy !== 1'b0) $display("FAIL full_in_rdy got=%b exp=0", bus.in_rdy); else n_pass++;
        n_chk++; if (bus.entry_cnt !== 3'd4) $display("FAIL full_cnt got=%0d exp=4", bus.entry_cnt); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.entry_cnt !== 3'd4) $display("FAIL full_cnt_after got=%0d exp=4", bus.entry_cnt); else n_pass++;
        for (int i = 0; i < NUM; i++) begin
            step(1'b0, '0, 1'b1);
            n_chk++;
            if (bus.out_data !== DW'(64'h10 + i)) $display("FAIL full_drain%0d got=%h exp=%h", i, bus.out_data, 64'h10 + i);
            else n_pass++;
        end
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL full_empty got=%b exp=1", bus.empty); else n_pass++;
    endtask

    task automatic test_lock_hold();
        step(1'b1, 64'h30, 1'b0);
        step(1'b1, 64'h31, 1'b0);
        step(1'b1, 64'h32, 1'b0);
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_data !== 64'h30) $display("FAIL lock_d0 got=%h exp=30", bus.out_data); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_data !== 64'h31) $display("FAIL lock_d1 got=%h exp=31", bus.out_data); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.out_data !== 64'h32) $display("FAIL lock_d2 got=%h exp=32", bus.out_data); else n_pass++;
        step(1'b1, 64'h77, 1'b0);
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.arb_valid !== 4'b0100) $display("FAIL lock_mask got=%b exp=0100", bus.arb_valid); else n_pass++;
        n_chk++; if (bus.out_data !== 64'h32) $display("FAIL lock_stable got=%h exp=32", bus.out_data); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.arb_clr !== 1'b1) $display("FAIL lock_clr got=%b exp=1", bus.arb_clr); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_data !== 64'h77) $display("FAIL lock_next got=%h exp=77", bus.out_data); else n_pass++;
        n_chk++; if (bus.arb_valid !== 4'b0001) $display("FAIL lock_next_vld got=%b exp=0001", bus.arb_valid); else n_pass++;
        step(1'b0, '0, 1'b0);
    endtask

    task automatic test_full_accept_alloc();
        for (int i = 0; i < NUM; i++) step(1'b1, DW'(64'h40 + i), 1'b0);
        step(1'b1, 64'h50, 1'b1);
        n_chk++; if (bus.in_rdy !== 1'b0) $display("FAIL fa_in_rdy0 got=%b exp=0", bus.in_rdy); else n_pass++;
        n_chk++; if (bus.out_data !== 64'h40) $display("FAIL fa_d0 got=%h exp=40", bus.out_data); else n_pass++;
        step(1'b1, 64'h50, 1'b0);
        n_chk++; if (bus.entry_cnt !== 3'd3) $display("FAIL fa_cnt3 got=%0d exp=3", bus.entry_cnt); else n_pass++;
        n_chk++; if (bus.in_rdy !== 1'b1) $display("FAIL fa_in_rdy1 got=%b exp=1", bus.in_rdy); else n_pass++;
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.entry_cnt !== 3'd4) $display("FAIL fa_cnt4 got=%0d exp=4", bus.entry_cnt); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_data !== 64'h41) $display("FAIL fa_d1 got=%h exp=41", bus.out_data); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.out_data !== 64'h50) $display("FAIL fa_reuse got=%h exp=50", bus.out_data); else n_pass++;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        n_chk++; if (bus.empty !== 1'b1) $display("FAIL fa_empty got=%b exp=1", bus.empty); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(64'h60 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        #2 rst_b = 1'b0;
        @(posedge clk); @(negedge clk);
        n_chk++; if (bus.out_vld !== 1'b0) $display("FAIL mid_vld got=%b exp=0", bus.out_vld); else n_pass++;
        n_chk++; if (bus.entry_cnt !== 3'd0) $display("FAIL mid_cnt got=%0d exp=0", bus.entry_cnt); else n_pass++;
        n_chk++; if (bus.in_rdy !== 1'b1) $display("FAIL mid_in_rdy got=%b exp=1", bus.in_rdy); else n_pass++;
        @(posedge clk); #1 rst_b = 1'b1;
        step(1'b0, '0, 1'b1);
        n_chk++; if (bus.arb_valid !== 4'b0) $display("FAIL mid_arb got=%b exp=0000", bus.arb_valid); else n_pass++;
    endtask

    task automatic test_random();
        int pct;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pct = (c < 200) ? 15 : (c < 400) ? 60 : 95;
            step(1'($urandom_range(0, 99) < 70), {$urandom, $urandom}, 1'($urandom_range(0, 99) < pct));
            n_chk++; if (bus.out_vld !== m_ovld) $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, bus.out_vld, m_ovld); else n_pass++;
            if (m_ovld) begin
                n_chk++; if (bus.out_data !== m_odata) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.out_data, m_odata); else n_pass++;
            end
            n_chk++; if (bus.arb_valid !== m_valid) $display("FAIL rnd_arb c=%0d got=%b exp=%b", c, bus.arb_valid, m_valid); else n_pass++;
            n_chk++; if (bus.arb_clr !== m_clr) $display("FAIL rnd_clr c=%0d got=%b exp=%b", c, bus.arb_clr, m_clr); else n_pass++;
            n_chk++; if (bus.entry_cnt !== CNT_W'(m_cnt)) $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bus.entry_cnt, m_cnt); else n_pass++;
            n_chk++; if (bus.in_rdy !== (m_cnt < NUM)) $display("FAIL rnd_in_rdy c=%0d got=%b exp=%b", c, bus.in_rdy, m_cnt < NUM); else n_pass++;
            n_chk++; if (bus.full !== (m_cnt == NUM)) $display("FAIL rnd_full c=%0d got=%b exp=%b", c, bus.full, m_cnt == NUM); else n_pass++;
            n_chk++; if (bus.empty !== (m_cnt == 0)) $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, bus.empty, m_cnt == 0); else n_pass++;
        end
    endtask

    initial begin
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
        test_reset();
        test_single(64'hA5);
        test_full();
        test_lock_hold();
        test_full_accept_alloc();
        test_reset_mid();
        test_single(64'h3C);
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
